// File: rtl/conv_layer_sched_if.sv
// Control, engine handshake and shared layer-memory port bundle for conv_layer_sched.
// The master modport is the scheduler's view; slave is the host/engine/memory side.
interface conv_layer_sched_if;
  logic        ready;
  logic        busy;
  logic        err;
  logic        viol;
  logic        ksel;

  logic        conv_start;
  logic        pool_start;
  logic        flat_start;
  logic        conv_done;
  logic        pool_done;
  logic        flat_done;

  logic        conv_cwr;
  logic [11:0] conv_caddr_wr;
  logic [19:0] conv_cdata_wr;

  logic        pool_crd;
  logic [11:0] pool_caddr_rd;
  logic        pool_cwr;
  logic [11:0] pool_caddr_wr;
  logic [19:0] pool_cdata_wr;
  logic        pool_wph;

  logic        flat_crd;
  logic [11:0] flat_caddr_rd;
  logic        flat_cwr;
  logic [11:0] flat_caddr_wr;
  logic [19:0] flat_cdata_wr;
  logic        flat_src;
  logic        flat_wph;

  logic        cwr;
  logic [11:0] caddr_wr;
  logic [19:0] cdata_wr;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [2:0]  csel;

  modport master (
    input  ready, conv_done, pool_done, flat_done,
    input  conv_cwr, conv_caddr_wr, conv_cdata_wr,
    input  pool_crd, pool_caddr_rd, pool_cwr, pool_caddr_wr, pool_cdata_wr, pool_wph,
    input  flat_crd, flat_caddr_rd, flat_cwr, flat_caddr_wr, flat_cdata_wr, flat_src, flat_wph,
    output busy, err, viol, ksel, conv_start, pool_start, flat_start,
    output cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );

  modport slave (
    output ready, conv_done, pool_done, flat_done,
    output conv_cwr, conv_caddr_wr, conv_cdata_wr,
    output pool_crd, pool_caddr_rd, pool_cwr, pool_caddr_wr, pool_cdata_wr, pool_wph,
    output flat_crd, flat_caddr_rd, flat_cwr, flat_caddr_wr, flat_cdata_wr, flat_src, flat_wph,
    input  busy, err, viol, ksel, conv_start, pool_start, flat_start,
    input  cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );
endinterface

// File: rtl/conv_layer_sched.sv
// Sequences conv/pool/flatten engines over both kernels and arbitrates the single
// layer-memory port to whichever engine owns the current stage.
module conv_layer_sched #(
  parameter int TIMEOUT = 20000,
  parameter int TW      = 15
) (
  input logic                 clk,
  input logic                 reset,
  conv_layer_sched_if.master  bus
);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_WAIT, ST_FIN, ST_ERR} state_t;
  typedef enum logic [2:0] {L0K0, L0K1, L1K0, L1K1, L2}                 stage_t;
  typedef enum logic [1:0] {ENG_CONV, ENG_POOL, ENG_FLAT}               eng_t;

  state_t        state, state_nx;
  stage_t        stage, stage_nx;
  logic [TW-1:0] wdog, wdog_nx, wdog_inc;
  logic          busy_q, busy_nx;
  logic          err_q, err_nx;
  logic          viol_q, viol_nx;

  eng_t eng;
  logic port_on;
  logic act_done;
  logic stray_req;

  function automatic stage_t next_stage(input stage_t s);
    case (s)
      L0K0:    return L0K1;
      L0K1:    return L1K0;
      L1K0:    return L1K1;
      default: return L2;
    endcase
  endfunction

  assign port_on  = (state == ST_START) || (state == ST_WAIT);
  assign wdog_inc = wdog + 1'b1;

  // NOTE: every combinational output gets a default before any branch, so no path
  // can leave a value unassigned and infer a latch.
  always_comb begin
    eng       = ENG_FLAT;
    act_done  = 1'b0;
    stray_req = 1'b0;
    case (stage)
      L0K0, L0K1: eng = ENG_CONV;
      L1K0, L1K1: eng = ENG_POOL;
      default:    eng = ENG_FLAT;
    endcase
    case (eng)
      ENG_CONV: begin
        act_done  = bus.conv_done;
        stray_req = bus.pool_crd | bus.pool_cwr | bus.flat_crd | bus.flat_cwr;
      end
      ENG_POOL: begin
        act_done  = bus.pool_done;
        stray_req = bus.conv_cwr | bus.flat_crd | bus.flat_cwr;
      end
      default: begin
        act_done  = bus.flat_done;
        stray_req = bus.conv_cwr | bus.pool_crd | bus.pool_cwr;
      end
    endcase
  end

  always_comb begin
    state_nx = state;
    stage_nx = stage;
    wdog_nx  = wdog;
    err_nx   = err_q;
    viol_nx  = viol_q | (port_on & stray_req);
    case (state)
      ST_IDLE, ST_ERR: begin
        if (bus.ready) begin
          state_nx = ST_START;
          stage_nx = L0K0;
          err_nx   = 1'b0;
          viol_nx  = 1'b0;
        end
      end
      ST_START: begin
        wdog_nx  = '0;
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        wdog_nx = wdog_inc;
        // A done in the final allowed cycle takes priority over the watchdog.
        if (act_done) begin
          if (stage == L2) begin
            state_nx = ST_FIN;
          end else begin
            stage_nx = next_stage(stage);
            state_nx = ST_START;
          end
        end else if (wdog_inc == TW'(TIMEOUT)) begin
          state_nx = ST_ERR;
          err_nx   = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    busy_nx = (state_nx == ST_START) || (state_nx == ST_WAIT) || (state_nx == ST_FIN);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      stage  <= L0K0;
      wdog   <= '0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
      viol_q <= 1'b0;
    end else begin
      state  <= state_nx;
      stage  <= stage_nx;
      wdog   <= wdog_nx;
      busy_q <= busy_nx;
      err_q  <= err_nx;
      viol_q <= viol_nx;
    end
  end

  assign bus.busy = busy_q;
  assign bus.err  = err_q;
  assign bus.viol = viol_q;
  assign bus.ksel = (stage == L0K1) || (stage == L1K1);

  assign bus.conv_start = (state == ST_START) && (eng == ENG_CONV);
  assign bus.pool_start = (state == ST_START) && (eng == ENG_POOL);
  assign bus.flat_start = (state == ST_START) && (eng == ENG_FLAT);

  // Only the owning engine reaches the port; inactive requests are dropped here.
  always_comb begin
    bus.cwr      = 1'b0;
    bus.caddr_wr = '0;
    bus.cdata_wr = '0;
    bus.crd      = 1'b0;
    bus.caddr_rd = '0;
    bus.csel     = 3'b000;
    if (port_on) begin
      case (eng)
        ENG_CONV: begin
          bus.cwr      = bus.conv_cwr;
          bus.caddr_wr = bus.conv_caddr_wr;
          bus.cdata_wr = bus.conv_cdata_wr;
          bus.csel     = (stage == L0K1) ? 3'b010 : 3'b001;
        end
        ENG_POOL: begin
          bus.cwr      = bus.pool_cwr;
          bus.caddr_wr = bus.pool_caddr_wr;
          bus.cdata_wr = bus.pool_cdata_wr;
          bus.crd      = bus.pool_crd;
          bus.caddr_rd = bus.pool_caddr_rd;
          bus.csel     = 3'b001 + {1'b0, bus.pool_wph, 1'b0} + {2'b00, stage == L1K1};
        end
        default: begin
          bus.cwr      = bus.flat_cwr;
          bus.caddr_wr = bus.flat_caddr_wr;
          bus.cdata_wr = bus.flat_cdata_wr;
          bus.crd      = bus.flat_crd;
          bus.caddr_rd = bus.flat_caddr_rd;
          bus.csel     = bus.flat_wph ? 3'b101 : (3'b011 + {2'b00, bus.flat_src});
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_sched.sv
// Directed bench for conv_layer_sched: a stage-level reference model is compared every
// cycle, and hand-computed literals pin sequencing, bank mapping, violation and watchdog.
module tb_conv_layer_sched;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic reset;
  conv_layer_sched_if bus();

  conv_layer_sched #(.TIMEOUT(TIMEOUT), .TW(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 start, 2 wait, 3 fin, 4 err; stage 0..4 in run order.
  int m_phase = 0, m_stage = 0, m_wcnt = 0;
  bit m_busy = 0, m_err = 0, m_viol = 0, model_on = 0;

  task automatic model_step();
    int  e;
    bit  bad, dn;
    if (reset) begin
      m_phase = 0; m_stage = 0; m_wcnt = 0;
      m_err = 0; m_viol = 0; model_on = 1;
    end else begin
      e   = m_stage / 2;
      bad = (e != 0 && bus.conv_cwr) || (e != 1 && (bus.pool_crd || bus.pool_cwr)) ||
            (e != 2 && (bus.flat_crd || bus.flat_cwr));
      dn  = (e == 0) ? bus.conv_done : (e == 1) ? bus.pool_done : bus.flat_done;
      if ((m_phase == 1 || m_phase == 2) && bad) m_viol = 1;
      case (m_phase)
        0, 4: if (bus.ready) begin m_phase = 1; m_stage = 0; m_err = 0; m_viol = 0; end
        1: begin m_phase = 2; m_wcnt = 0; end
        2: begin
          m_wcnt++;
          if (dn) begin
            if (m_stage == 4) m_phase = 3;
            else begin m_stage++; m_phase = 1; end
          end else if (m_wcnt == TIMEOUT) begin
            m_phase = 4; m_err = 1;
          end
        end
        default: m_phase = 0;
      endcase
    end
    m_busy = (m_phase >= 1 && m_phase <= 3);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    logic [6:0]  exp_ctrl;
    logic [48:0] exp_port;
    int          e, cs;
    bit          act;
    @(negedge clk);
    if (model_on) begin
      e   = m_stage / 2;
      act = (m_phase == 1 || m_phase == 2);
      exp_ctrl = {m_busy, m_err, m_viol, (m_stage == 1 || m_stage == 3),
                  m_phase == 1 && e == 0, m_phase == 1 && e == 1, m_phase == 1 && e == 2};
      exp_port = '0;
      if (act) begin
        case (e)
          0: begin
            cs = 1 + m_stage;
            exp_port = {bus.conv_cwr, bus.conv_caddr_wr, bus.conv_cdata_wr, 1'b0, 12'h000, 3'(cs)};
          end
          1: begin
            cs = 1 + (m_stage - 2) + (bus.pool_wph ? 2 : 0);
            exp_port = {bus.pool_cwr, bus.pool_caddr_wr, bus.pool_cdata_wr,
                        bus.pool_crd, bus.pool_caddr_rd, 3'(cs)};
          end
          default: begin
            cs = bus.flat_wph ? 5 : 3 + int'(bus.flat_src);
            exp_port = {bus.flat_cwr, bus.flat_caddr_wr, bus.flat_cdata_wr,
                        bus.flat_crd, bus.flat_caddr_rd, 3'(cs)};
          end
        endcase
      end
      check("cyc_ctrl", {bus.busy, bus.err, bus.viol, bus.ksel,
                         bus.conv_start, bus.pool_start, bus.flat_start}, exp_ctrl);
      check("cyc_port", {bus.cwr, bus.caddr_wr, bus.cdata_wr, bus.crd, bus.caddr_rd, bus.csel},
            exp_port);
    end
  end

  // Engine responder: answers the first auto_upto starts with done after done_delay cycles.
  int         done_delay = 4;
  int         auto_upto  = 0;
  int         n_seen     = 0;
  logic [2:0] inj_done   = 3'b000;

  initial begin
    int p_cnt, p_eng;
    p_cnt = 0; p_eng = 0;
    bus.conv_done = 0; bus.pool_done = 0; bus.flat_done = 0;
    forever begin
      @(negedge clk);
      if (bus.conv_start || bus.pool_start || bus.flat_start) begin
        if (n_seen < auto_upto) begin
          p_cnt = done_delay;
          p_eng = bus.pool_start ? 1 : (bus.flat_start ? 2 : 0);
        end
        n_seen++;
      end
      @(posedge clk); #1;
      bus.conv_done = inj_done[0];
      bus.pool_done = inj_done[1];
      bus.flat_done = inj_done[2];
      if (p_cnt > 0) begin
        p_cnt--;
        if (p_cnt == 0) begin
          case (p_eng)
            0:       bus.conv_done = 1'b1;
            1:       bus.pool_done = 1'b1;
            default: bus.flat_done = 1'b1;
          endcase
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clear_eng();
    bus.conv_cwr = 0; bus.conv_caddr_wr = '0; bus.conv_cdata_wr = '0;
    bus.pool_crd = 0; bus.pool_caddr_rd = '0; bus.pool_cwr = 0;
    bus.pool_caddr_wr = '0; bus.pool_cdata_wr = '0; bus.pool_wph = 0;
    bus.flat_crd = 0; bus.flat_caddr_rd = '0; bus.flat_cwr = 0;
    bus.flat_caddr_wr = '0; bus.flat_cdata_wr = '0; bus.flat_src = 0; bus.flat_wph = 0;
  endtask

  // Pulses ready for one cycle; returns during the resulting START cycle.
  task automatic kick();
    cyc(); bus.ready = 1;
    cyc(); bus.ready = 0;
  endtask

  int starts_q[$];

  task automatic run_monitor(input int budget, output int nbusy, output int gap);
    bit seen;
    int fd, fall;
    nbusy = 0; seen = 0; fd = -100; fall = -1;
    starts_q.delete();
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.busy) begin nbusy++; seen = 1; end
      if (bus.conv_start) starts_q.push_back(int'(bus.ksel));
      if (bus.pool_start) starts_q.push_back(2 + int'(bus.ksel));
      if (bus.flat_start) starts_q.push_back(4 + int'(bus.ksel));
      if (bus.flat_done) fd = i;
      if (seen && !bus.busy) begin fall = i; break; end
    end
    if (fall < 0) check("run_finished", 1'b0, 1'b1);
    gap = fall - fd;
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int         nbusy, gap, t;
    bit         found;
    logic [14:0] order;

    reset = 1; bus.ready = 0; clear_eng();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_flags", {bus.err, bus.viol, bus.ksel}, 3'b000);
    check("rst_starts", {bus.conv_start, bus.pool_start, bus.flat_start}, 3'b000);
    check("rst_port", {bus.cwr, bus.crd, bus.csel}, 5'b0);
    cyc(); reset = 0;

    // Nominal run: each stage occupies 5 cycles.
    done_delay = 4; auto_upto = n_seen + 5;
    kick();
    run_monitor(100, nbusy, gap);
    check("nom_busy_cycles", nbusy, 26);
    check("nom_done_to_idle", gap, 2);
    order = '0;
    foreach (starts_q[i]) order = {order[11:0], 3'(starts_q[i])};
    check("nom_start_count", starts_q.size(), 5);
    check("nom_start_order", order, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4});

    // Minimum run: done in the first WAIT cycle of every stage.
    done_delay = 1; auto_upto = n_seen + 5;
    kick();
    run_monitor(60, nbusy, gap);
    check("min_busy_cycles", nbusy, 11);

    // Bank mapping in L1K1, then flatten mapping in L2.
    auto_upto = n_seen + 3;
    kick();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      found = bus.pool_start && bus.ksel;
    end
    check("reach_l1k1", found, 1'b1);
    cyc(); bus.pool_wph = 0; bus.pool_crd = 1; bus.pool_caddr_rd = 12'h041;
    @(negedge clk);
    check("l1k1_rd_csel", bus.csel, 3'b010);
    check("l1k1_rd_port", {bus.crd, bus.caddr_rd}, {1'b1, 12'h041});
    cyc(); bus.pool_crd = 0; bus.pool_wph = 1; bus.pool_cwr = 1;
    bus.pool_caddr_wr = 12'h7F0; bus.pool_cdata_wr = 20'h00ABC;
    @(negedge clk);
    check("l1k1_wr_csel", bus.csel, 3'b100);
    check("l1k1_wr_port", {bus.cwr, bus.caddr_wr, bus.cdata_wr}, {1'b1, 12'h7F0, 20'h00ABC});
    inj_done = 3'b010;
    cyc(); clear_eng();
    @(negedge clk); inj_done = 3'b000;
    cyc();
    @(negedge clk);
    check("l2_start", {bus.flat_start, bus.ksel}, 2'b10);
    cyc(); bus.flat_src = 1; bus.flat_wph = 0; bus.flat_crd = 1; bus.flat_caddr_rd = 12'h3A5;
    @(negedge clk);
    check("l2_src1_csel", bus.csel, 3'b100);
    check("l2_rd_port", {bus.crd, bus.caddr_rd}, {1'b1, 12'h3A5});
    cyc(); bus.flat_wph = 1; bus.flat_crd = 0; bus.flat_cwr = 1;
    bus.flat_caddr_wr = 12'h0FF; bus.flat_cdata_wr = 20'h12345;
    @(negedge clk);
    check("l2_wph_csel", bus.csel, 3'b101);
    check("l2_wr_port", {bus.cwr, bus.cdata_wr}, {1'b1, 20'h12345});
    inj_done = 3'b100;
    cyc(); clear_eng();
    @(negedge clk); inj_done = 3'b000;
    cyc();
    @(negedge clk);
    check("fin_state", {bus.busy, bus.csel}, {1'b1, 3'b000});
    cyc();
    @(negedge clk);
    check("fin_to_idle", bus.busy, 1'b0);

    // Violation during L0K0, then watchdog expiry with conv_done withheld.
    auto_upto = n_seen;
    kick();
    cyc(); bus.conv_cwr = 1; bus.conv_caddr_wr = 12'h123; bus.conv_cdata_wr = 20'h11111;
    bus.pool_cwr = 1; bus.pool_caddr_wr = 12'hEEE; bus.pool_cdata_wr = 20'hFFFFF;
    @(negedge clk);
    check("viol_mux", {bus.cwr, bus.caddr_wr, bus.cdata_wr}, {1'b1, 12'h123, 20'h11111});
    check("viol_not_yet", bus.viol, 1'b0);
    cyc(); bus.pool_cwr = 0;
    @(negedge clk);
    check("viol_set", bus.viol, 1'b1);
    t = 2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      t++;
      if (bus.err) break;
    end
    check("wd_cycles", t, 9);
    check("err_state", {bus.err, bus.busy, bus.viol}, 3'b101);
    check("err_port", {bus.cwr, bus.crd, bus.caddr_wr, bus.cdata_wr, bus.csel}, 49'h0);

    // Restart from ERR, then reset in the middle of L1K0 WAIT.
    done_delay = 1; auto_upto = n_seen + 2;
    cyc(); clear_eng(); bus.ready = 1;
    cyc(); bus.ready = 0;
    @(negedge clk);
    check("restart_flags", {bus.err, bus.viol, bus.conv_start, bus.busy}, 4'b0011);
    check("restart_csel", bus.csel, 3'b001);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      found = bus.pool_start && !bus.ksel;
    end
    check("reach_l1k0", found, 1'b1);
    cyc(); reset = 1;
    @(negedge clk);
    cyc(); reset = 0;
    @(negedge clk);
    check("rst_mid_busy", {bus.busy, bus.csel, bus.ksel}, 5'b0);
    inj_done = 3'b010;
    cyc();
    @(negedge clk); inj_done = 3'b000;
    for (int i = 0; i < 4; i++) begin
      check("late_done_ignored", {bus.busy, bus.conv_start, bus.pool_start, bus.flat_start}, 4'b0);
      cyc();
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
